// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: valid/ready configuration channel for the LED pattern sequencer.
interface led_pattern_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_rate;
  modport master (output cfg_valid, cfg_mode, cfg_rate, input cfg_ready);
  modport slave (input cfg_valid, cfg_mode, cfg_rate, output cfg_ready);
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: prescaled off/blink/chase/PWM-breathe LED sequencer with run-time configuration.
module led_pattern_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int PWM_BITS = 4,
  parameter int LED_W    = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  led_pattern_ctrl_if.slave  cfg,
  output logic [LED_W-1:0]   led,
  output logic [1:0]         mode_o,
  output logic               step_pulse
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [1:0] OFF = 2'd0, BLINK = 2'd1, CHASE = 2'd2, BREATHE = 2'd3;
  typedef enum logic {RUN, APPLY} state_t;
  state_t              state;
  logic [TW-1:0]       tick_cnt;
  logic [7:0]          step_cnt, rate;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  logic                dir_up;
  logic [LED_W-1:0]    pat, pat_nxt, pat_init;
  logic                tick, accept, adv, up_eff;
  always_comb begin
    tick     = tick_cnt == TW'(TICK_DIV - 1);
    accept   = state == RUN && cfg.cfg_valid && cfg.cfg_ready;
    adv      = state == RUN && tick && step_cnt == rate - 8'd1 && !accept;
    // Bounce off the ends instead of wrapping: each end value lasts a single step.
    up_eff   = duty == '0 ? 1'b1 : &duty ? 1'b0 : dir_up;
    pat_nxt  = !adv ? pat : mode_o == BLINK ? ~pat : {pat[LED_W-2:0], pat[LED_W-1]};
    pat_init = mode_o == BLINK ? '1 : mode_o == CHASE ? LED_W'(1) : '0;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= RUN;
      cfg.cfg_ready <= 1'b1;
      tick_cnt      <= '0;
      step_cnt      <= '0;
      rate          <= 8'd1;
      pwm_cnt       <= '0;
      duty          <= '0;
      dir_up        <= 1'b1;
      pat           <= '0;
      led           <= '0;
      mode_o        <= OFF;
      step_pulse    <= 1'b0;
    end else if (state == APPLY) begin
      state         <= RUN;
      cfg.cfg_ready <= 1'b1;
      tick_cnt      <= '0;
      step_cnt      <= '0;
      pwm_cnt       <= '0;
      duty          <= '0;
      dir_up        <= 1'b1;
      pat           <= pat_init;
      led           <= pat_init;
      step_pulse    <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
      step_cnt   <= !tick ? step_cnt : step_cnt == rate - 8'd1 ? 8'd0 : step_cnt + 8'd1;
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      step_pulse <= adv;
      pat        <= pat_nxt;
      if (adv) begin
        duty   <= up_eff ? duty + PWM_BITS'(1) : duty - PWM_BITS'(1);
        dir_up <= up_eff;
      end
      led <= accept ? '0 : mode_o == OFF ? '0 :
             mode_o == BREATHE ? {LED_W{pwm_cnt < duty}} : pat_nxt;
      if (accept) begin
        state         <= APPLY;
        cfg.cfg_ready <= 1'b0;
        mode_o        <= cfg.cfg_mode;
        rate          <= cfg.cfg_rate == 8'd0 ? 8'd1 : cfg.cfg_rate;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: randomized self-checking bench against a closed-form pattern model.
module tb_led_pattern_ctrl;
  localparam int TD = 4;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] led;
  logic [1:0] mode_o;
  logic       step_pulse;
  int         checks = 0;
  int         passed = 0;
  led_pattern_ctrl_if cfg();
  led_pattern_ctrl #(.TICK_DIV(TD), .PWM_BITS(4), .LED_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg(cfg),
    .led(led), .mode_o(mode_o), .step_pulse(step_pulse)
  );
  always #5 sys_clk = ~sys_clk;

  // Duty after k steps: triangle 0..15..0 with period 30 steps.
  function automatic int tri_duty(input int k);
    int p;
    p = k % 30;
    return p <= 15 ? p : 30 - p;
  endfunction

  // n = cycles since leaving APPLY (or reset release), p = cycles per step.
  function automatic logic [3:0] exp_led(input logic [1:0] m, input int n, input int p);
    int k;
    k = n / p;
    case (m)
      2'd1: return (k % 2 == 0) ? 4'hf : 4'h0;
      2'd2: return 4'b0001 << (k % 4);
      2'd3: return (n == 0) ? 4'h0 : (((n - 1) % 16) < tri_duty((n - 1) / p)) ? 4'hf : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  task automatic run_check(input logic [1:0] m, input int p, input int cyc);
    logic [3:0] el;
    logic       ep;
    for (int n = 0; n < cyc; n++) begin
      el = exp_led(m, n, p);
      ep = (n > 0) && (n % p == 0);
      checks++;
      if (led !== el) $display("FAIL led mode=%0d n=%0d: got %b want %b", m, n, led, el);
      else passed++;
      checks++;
      if (step_pulse !== ep) $display("FAIL step_pulse mode=%0d n=%0d: got %b want %b", m, n, step_pulse, ep);
      else passed++;
      checks++;
      if (mode_o !== m || cfg.cfg_ready !== 1'b1)
        $display("FAIL run_state n=%0d: mode_o=%0d ready=%b want mode_o=%0d ready=1", n, mode_o, cfg.cfg_ready, m);
      else passed++;
      @(negedge sys_clk);
    end
  endtask

  task automatic do_config(input logic [1:0] m, input logic [7:0] r);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_mode  = m;
    cfg.cfg_rate  = r;
    checks++;
    if (cfg.cfg_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", cfg.cfg_ready);
    else passed++;
    @(negedge sys_clk);
    checks++;
    if (cfg.cfg_ready !== 1'b0 || led !== 4'h0 || step_pulse !== 1'b0)
      $display("FAIL apply_cycle: ready=%b led=%b pulse=%b want ready=0 led=0000 pulse=0", cfg.cfg_ready, led, step_pulse);
    else passed++;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_mode  = 2'($urandom);
    cfg.cfg_rate  = 8'($urandom);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    cfg.cfg_valid = 1'b0;
    cfg.cfg_mode  = 2'd0;
    cfg.cfg_rate  = 8'd0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (led !== 4'h0 || mode_o !== 2'd0 || cfg.cfg_ready !== 1'b1 || step_pulse !== 1'b0)
      $display("FAIL reset_values: led=%b mode=%0d ready=%b pulse=%b want 0000/0/1/0", led, mode_o, cfg.cfg_ready, step_pulse);
    else passed++;
    sys_rst_n = 1'b1;
    run_check(2'd0, TD, 100);
  endtask

  task automatic test_chase();
    do_config(2'd2, 8'd2);
    run_check(2'd2, 2 * TD, 40);
  endtask

  task automatic test_blink();
    do_config(2'd1, 8'd0);
    run_check(2'd1, TD, 20);
  endtask

  task automatic test_breathe();
    int r;
    do_config(2'd3, 8'd1);
    run_check(2'd3, TD, 140);
    r = $urandom_range(4, 6);
    do_config(2'd3, 8'(r));
    run_check(2'd3, r * TD, 31 * r * TD);
  endtask

  task automatic test_back_to_back();
    int r;
    r = $urandom_range(1, 3);
    do_config(2'd2, 8'(r));
    run_check(2'd2, r * TD, 3 * r * TD - 1);
    checks++;
    if (led !== 4'b0100) $display("FAIL collide_pre: got %b want 0100", led);
    else passed++;
    do_config(2'd2, 8'(r));
    run_check(2'd2, r * TD, 2 * r * TD + 1);
  endtask

  task automatic test_random();
    logic [1:0] m;
    int         r;
    for (int i = 0; i < 6; i++) begin
      m = 2'($urandom);
      r = $urandom_range(0, 4);
      do_config(m, 8'(r));
      run_check(m, (r == 0 ? 1 : r) * TD, $urandom_range(20, 120));
    end
  endtask

  task automatic test_async_reset();
    do_config(2'd3, 8'd1);
    run_check(2'd3, TD, 60);
    #2;
    sys_rst_n     = 1'b0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_mode  = 2'd2;
    cfg.cfg_rate  = 8'd3;
    #1;
    checks++;
    if (led !== 4'h0 || mode_o !== 2'd0 || cfg.cfg_ready !== 1'b1 || step_pulse !== 1'b0)
      $display("FAIL async_reset: led=%b mode=%0d ready=%b pulse=%b want 0000/0/1/0", led, mode_o, cfg.cfg_ready, step_pulse);
    else passed++;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (led !== 4'h0 || mode_o !== 2'd0 || cfg.cfg_ready !== 1'b1)
      $display("FAIL reset_hold: led=%b mode=%0d ready=%b want 0000/0/1", led, mode_o, cfg.cfg_ready);
    else passed++;
    @(negedge sys_clk);
    cfg.cfg_valid = 1'b0;
    sys_rst_n     = 1'b1;
    run_check(2'd0, TD, 20);
  endtask

  initial begin
    test_reset();
    test_chase();
    test_blink();
    test_breathe();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
